// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC phase generator and the CORDIC_angle rotation stage:
// width constants, the 90-degree angle constant and the quadrant fold helper.
package cordic_pkg;

  localparam int PHASE_W = 24;
  localparam int Z_W     = 16;
  localparam logic [Z_W-1:0] ANGLE_90 = 16'h4000;

  typedef struct packed {
    logic           flip;
    logic [Z_W-1:0] z;
  } fold_t;

  // Angles outside [-90, +90) get 180 degrees added; the caller negates x and y to compensate.
  function automatic fold_t cordic_fold(input logic [Z_W-1:0] p);
    fold_t r;
    if (p[Z_W-1] == p[Z_W-2]) begin
      r.flip = 1'b0;
      r.z    = p;
    end else begin
      r.flip = 1'b1;
      r.z    = p ^ {ANGLE_90[Z_W-2:0], 1'b0};
    end
    return r;
  endfunction

endpackage

// File: rtl/cordic_phase_gen_if.sv
// Control and sample bus of the phase generator: master drives the tuning words,
// slave (the generator) returns the folded angle stream.
interface cordic_phase_gen_if #(
  parameter int Z_W = 16
);
  logic           en;
  logic [3:0]     W;
  logic [3:0]     A;
  logic [Z_W-1:0] z_out;
  logic           flip;
  logic [3:0]     a_out;
  logic           valid;
  logic           wrap;

  modport master (output en, W, A, input z_out, flip, a_out, valid, wrap);
  modport slave  (input en, W, A, output z_out, flip, a_out, valid, wrap);
endinterface

// File: rtl/cordic_phase_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1) supplying phase dither bits.
// Only instantiated when CORDIC_PHASE_DITHER_EN is defined.
module cordic_phase_lfsr #(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  output logic [OUT_W-1:0] dither_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb_s;

  assign fb_s     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign dither_o = lfsr_q[OUT_W-1:0];

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) begin
      lfsr_d = {lfsr_q[14:0], fb_s};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase accumulator and quadrant folder feeding the CORDIC rotation stage; retunes only at
// a phase wrap. Define CORDIC_PHASE_DITHER_EN to add LFSR dither before phase truncation.
module cordic_phase_gen #(
  parameter int PHASE_W   = cordic_pkg::PHASE_W,
  parameter int Z_W       = cordic_pkg::Z_W,
  parameter int INC_SHIFT = 12
) (
  input logic                clk,
  input logic                rst_n,
  cordic_phase_gen_if.slave  bus
);
  import cordic_pkg::*;

  logic [PHASE_W-1:0] acc_q;
  logic               c1_q;
  logic [3:0]         w_act_q;
  logic [3:0]         a_act_q;
  logic [Z_W-1:0]     z_out_q;
  logic               flip_q;
  logic [3:0]         a_out_q;
  logic               valid_q;
  logic               wrap_q;

  logic [PHASE_W-1:0] inc_act_s;
  logic [PHASE_W:0]   sum_s;
  logic [Z_W-1:0]     p_s;
  logic               retune_s;
  fold_t              fold_s;

  assign inc_act_s = PHASE_W'(w_act_q) << INC_SHIFT;
  assign sum_s     = {1'b0, acc_q} + {1'b0, inc_act_s};
  // An idle generator (w_act == 0) never carries, so it must accept new words every edge.
  assign retune_s  = (bus.en && sum_s[PHASE_W]) || (w_act_q == 4'd0);

`ifdef CORDIC_PHASE_DITHER_EN
  localparam int DW = PHASE_W - Z_W;
  logic [DW-1:0]      dither_s;
  logic [PHASE_W-1:0] dith_acc_s;

  cordic_phase_lfsr #(.OUT_W(DW)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv_i    (bus.en),
    .dither_o (dither_s)
  );

  assign dith_acc_s = acc_q + PHASE_W'(dither_s);
  assign p_s        = dith_acc_s[PHASE_W-1 -: Z_W];
`else
  assign p_s = acc_q[PHASE_W-1 -: Z_W];
`endif

  assign fold_s = cordic_fold(p_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      c1_q    <= 1'b0;
      w_act_q <= 4'd0;
      a_act_q <= 4'd0;
      z_out_q <= '0;
      flip_q  <= 1'b0;
      a_out_q <= 4'd0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      if (bus.en) begin
        acc_q   <= sum_s[PHASE_W-1:0];
        c1_q    <= sum_s[PHASE_W];
        z_out_q <= fold_s.z;
        flip_q  <= fold_s.flip;
        a_out_q <= a_act_q;
        wrap_q  <= c1_q;
      end
      if (retune_s) begin
        w_act_q <= bus.W;
        a_act_q <= bus.A;
      end
      valid_q <= bus.en;
    end
  end

  assign bus.z_out = z_out_q;
  assign bus.flip  = flip_q;
  assign bus.a_out = a_out_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed bench for cordic_phase_gen (default build): reset, fold table, period,
// retune at wrap, frozen phase with W=0, enable stall and asynchronous reset.
module tb_cordic_phase_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cordic_phase_gen_if #(.Z_W(16)) bus ();

  cordic_phase_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          s;
    logic [15:0] z;
    logic        f;
  } fold_vec_t;

  fold_vec_t fv[7];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference fold, stated as signed-angle range checks.
  function automatic logic [16:0] ref_fold(input int p);
    int sp;
    int zz;
    logic f;
    sp = (p >= 32768) ? p - 65536 : p;
    if (sp >= 16384) begin
      zz = sp - 32768; f = 1'b1;
    end else if (sp < -16384) begin
      zz = sp + 32768; f = 1'b1;
    end else begin
      zz = sp; f = 1'b0;
    end
    return {f, 16'(zz)};
  endfunction

  task automatic chk_sample(input string name, input int p, input logic exp_wrap);
    logic [16:0] r;
    r = ref_fold(p & 32'hFFFF);
    chk({name, "_z"}, 32'(bus.z_out), 32'(r[15:0]));
    chk({name, "_flip"}, 32'(bus.flip), 32'(r[16]));
    chk({name, "_wrap"}, 32'(bus.wrap), 32'(exp_wrap));
  endtask

  initial begin
    int s;
    int nw;
    int last;
    int exp_seq[4];

    fv[0] = '{s: 32'h3FF, z: 16'h3FF0, f: 1'b0};
    fv[1] = '{s: 32'h400, z: 16'hC000, f: 1'b1};
    fv[2] = '{s: 32'h7FF, z: 16'hFFF0, f: 1'b1};
    fv[3] = '{s: 32'h800, z: 16'h0000, f: 1'b1};
    fv[4] = '{s: 32'hBFF, z: 16'h3FF0, f: 1'b1};
    fv[5] = '{s: 32'hC00, z: 16'hC000, f: 1'b0};
    fv[6] = '{s: 32'hFFF, z: 16'hFFF0, f: 1'b0};

    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.W  = 4'd1;
    bus.A  = 4'd1;
    repeat (3) @(negedge clk);
    chk("rst_z", 32'(bus.z_out), 32'd0);
    chk("rst_flip", 32'(bus.flip), 32'd0);
    chk("rst_a", 32'(bus.a_out), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_wrap", 32'(bus.wrap), 32'd0);

    rst_n = 1'b1;
    tick();
    tick();
    chk("first_valid", 32'(bus.valid), 32'd1);
    chk("first_z", 32'(bus.z_out), 32'd0);
    chk("first_a", 32'(bus.a_out), 32'd1);
    chk("first_wrap", 32'(bus.wrap), 32'd0);
    s = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      s++;
      chk("step16_z", 32'(bus.z_out), 32'(16 * k));
    end

    for (int i = 0; i < 7; i++) begin
      while (s < fv[i].s) begin
        tick();
        s++;
      end
      chk("fold_z", 32'(bus.z_out), 32'(fv[i].z));
      chk("fold_flip", 32'(bus.flip), 32'(fv[i].f));
    end

    tick();
    chk("wrap1_wrap", 32'(bus.wrap), 32'd1);
    chk("wrap1_z", 32'(bus.z_out), 32'd0);

    nw = 0;
    last = 0;
    for (int i = 1; i <= 4096; i++) begin
      tick();
      if (bus.wrap) begin
        nw++;
        last = i;
      end
    end
    chk("period_wraps", 32'(nw), 32'd1);
    chk("period_len", 32'(last), 32'd4096);
    chk("period_z", 32'(bus.z_out), 32'd0);

    repeat (32'h200) tick();
    chk("pre_retune_z", 32'(bus.z_out), 32'h2000);
    bus.W = 4'd2;
    bus.A = 4'd2;
    for (int i = 1; i <= 3584; i++) begin
      tick();
      chk_sample("retune16", 32'h2000 + 16 * i, i == 3584);
      chk("retune_a", 32'(bus.a_out), (i == 3584) ? 32'd2 : 32'd1);
    end
    for (int i = 1; i <= 2048; i++) begin
      tick();
      chk_sample("step32", 32 * i, i == 2048);
    end
    chk("step32_a", 32'(bus.a_out), 32'd2);

    bus.W = 4'd0;
    for (int i = 1; i <= 2048; i++) begin
      tick();
      chk_sample("to_zero", 32 * i, i == 2048);
    end
    repeat (10) begin
      tick();
      chk("frozen_z", 32'(bus.z_out), 32'd0);
      chk("frozen_wrap", 32'(bus.wrap), 32'd0);
    end

    bus.W = 4'd4;
    exp_seq = '{0, 0, 64, 128};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("w4_z", 32'(bus.z_out), 32'(exp_seq[i]));
      chk("w4_valid", 32'(bus.valid), 32'd1);
    end

    bus.en = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_valid", 32'(bus.valid), 32'd0);
      chk("stall_z", 32'(bus.z_out), 32'd128);
    end
    bus.en = 1'b1;
    tick();
    chk("resume_z", 32'(bus.z_out), 32'd192);
    chk("resume_valid", 32'(bus.valid), 32'd1);
    tick();
    chk("resume2_z", 32'(bus.z_out), 32'd256);

    chk("pre_arst_a", 32'(bus.a_out), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_z", 32'(bus.z_out), 32'd0);
    chk("arst_flip", 32'(bus.flip), 32'd0);
    chk("arst_a", 32'(bus.a_out), 32'd0);
    chk("arst_valid", 32'(bus.valid), 32'd0);
    chk("arst_wrap", 32'(bus.wrap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
